pipe_stall_regs: RTL and testbench
==================================

Name: pipe_stall_regs

Overview:
- Sequential end of the load-use stall path.
- Holds the PC register, the IF/ID register and the ID/EX control/rt register.
- Consumes the hazard detector's PC_En, IFID_ctrl and stall_ctrl, and applies hold/bubble/flush.
- Feeds lw_detected and ID_EX_rt back to the hazard detector, and keeps a saturating stall counter and a sticky consistency-error flag.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CTRL_W, 9, width of decoded control bundle carried into ID/EX.
- MEMREAD_BIT, 3, index of MemRead within the control bundle; drives lw_detected.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- PC_En  input  1  1 = PC loads pc_next; 0 = PC holds.
- IFID_ctrl  input  1  1 = IF/ID loads; 0 = IF/ID holds.
- stall_ctrl  input  1  0 = insert bubble into ID/EX; 1 = normal.
- flush  input  1  taken branch/jump resolved downstream; kills IF/ID and ID/EX.
- pc_next  input  32  next PC from PC-select mux.
- instr_in  input  32  instruction fetched at PC.
- pc4_in  input  32  PC+4 of the fetched instruction.
- ctrl_in  input  CTRL_W  decoded control of the instruction in ID.
- PC  output  32  current fetch address.
- IF_ID_instr  output  32  instruction in ID.
- IF_ID_pc4  output  32  PC+4 of instruction in ID.
- IF_ID_rs  output  5  IF_ID_instr[25:21].
- IF_ID_rt  output  5  IF_ID_instr[20:16].
- ID_EX_ctrl  output  CTRL_W  control of instruction in EX.
- ID_EX_rt  output  5  rt of instruction in EX.
- lw_detected  output  1  ID_EX_ctrl[MEMREAD_BIT].
- stall_count  output  CNT_W  number of bubble cycles inserted.
- hazard_err  output  1  sticky; stall inputs were inconsistent.

Behaviour:
- Reset (reset=0, asynchronous): PC=RESET_PC; IF_ID_instr=0 (sll $0 NOP); IF_ID_pc4=0; ID_EX_ctrl=0; ID_EX_rt=0; stall_count=0; hazard_err=0. Derived outputs follow: IF_ID_rs=0, IF_ID_rt=0, lw_detected=0.
- Reset release: the first edge with reset=1 performs a normal update.
- All registers update on the rising edge of clk.
- IF_ID_rs, IF_ID_rt and lw_detected are combinational slices of registers (zero added latency).
- PC update:
  - PC_En=1: PC<=pc_next.
  - PC_En=0: PC holds.
  - flush does not affect PC; the branch target arrives via pc_next and PC_En.
  - If flush=1 and PC_En=0 in the same cycle, PC holds.
- IF/ID update, priority order:
  - flush=1: instr<=0, pc4<=0.
  - else IFID_ctrl=0: hold both.
  - else: instr<=instr_in, pc4<=pc4_in.
- ID/EX update, priority order:
  - flush=1 or stall_ctrl=0 (bubble): ID_EX_ctrl<=0, ID_EX_rt<=0.
  - else: ID_EX_ctrl<=ctrl_in, ID_EX_rt<=IF_ID_instr[20:16].
  - A bubble clears MemRead, so a stall lasts exactly one cycle per load-use pair: the next cycle lw_detected=0 and the hazard detector releases.
- Stall counter:
  - Increments by 1 on each edge where stall_ctrl=0 and flush=0.
  - Saturates at all-ones; no wrap.
  - Flush cycles are not counted.
- Consistency check:
  - Legal input combinations: (PC_En,IFID_ctrl,stall_ctrl)=(1,1,1) or (0,0,0).
  - On any edge with another combination, hazard_err<=1.
  - hazard_err stays 1 until reset. The register updates still follow the per-signal rules above.
- Reset mid-stall: all state is cleared immediately; the held instruction is discarded and fetch restarts at RESET_PC.

Test Plan:
- Reset: assert reset=0 mid-cycle with PC=0x0040_0010 -> PC=0x0040_0000, ID_EX_ctrl=0, stall_count=0 without waiting for a clk edge; release, pc_next=0x0040_0004, all enables=1 -> PC=0x0040_0004 after one edge.
- Normal flow: instr_in=0x8C08_0000 (lw $8,0($0)), ctrl_in MemRead=1 -> edge 1: IF_ID_instr=0x8C08_0000; edge 2: ID_EX_rt=8, lw_detected=1.
- Load-use stall: following step 2, drive (PC_En,IFID_ctrl,stall_ctrl)=(0,0,0) for one edge -> PC and IF_ID_instr unchanged, ID_EX_ctrl=0, lw_detected=0, stall_count=1; next edge with (1,1,1) -> dependent instruction enters EX.
- Flush priority: flush=1 together with stall (0,0,0) -> IF_ID_instr=0, ID_EX_ctrl=0, PC held, stall_count unchanged, hazard_err=0.
- Inconsistent controls: (PC_En,IFID_ctrl,stall_ctrl)=(1,0,1) for one edge -> hazard_err=1 and it remains 1 after returning to (1,1,1); cleared only by reset=0.
- Saturation: preset CNT_W=4, hold stall_ctrl=0 for 20 edges -> stall_count=15 and stays 15.

Source files
------------

// File: rtl/pipe_stall_regs.sv
// Sequential end of the load-use stall path: PC, IF/ID and ID/EX control/rt
// registers with hold/bubble/flush, a saturating stall counter and a sticky error flag.
module pipe_stall_regs #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter int unsigned CTRL_W      = 9,
  parameter int unsigned MEMREAD_BIT = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PC_En,
  input  logic              IFID_ctrl,
  input  logic              stall_ctrl,
  input  logic              flush,
  input  logic [31:0]       pc_next,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       pc4_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       PC,
  output logic [31:0]       IF_ID_instr,
  output logic [31:0]       IF_ID_pc4,
  output logic [4:0]        IF_ID_rs,
  output logic [4:0]        IF_ID_rt,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic [4:0]        ID_EX_rt,
  output logic              lw_detected,
  output logic [CNT_W-1:0]  stall_count,
  output logic              hazard_err
);

  logic legal;
  logic bubble;

  // The hazard detector drives all three enables together: all-run or all-stall.
  assign legal  = (PC_En & IFID_ctrl & stall_ctrl) | ~(PC_En | IFID_ctrl | stall_ctrl);
  assign bubble = flush | ~stall_ctrl;

  assign IF_ID_rs    = IF_ID_instr[25:21];
  assign IF_ID_rt    = IF_ID_instr[20:16];
  assign lw_detected = ID_EX_ctrl[MEMREAD_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC          <= RESET_PC;
      IF_ID_instr <= '0;
      IF_ID_pc4   <= '0;
      ID_EX_ctrl  <= '0;
      ID_EX_rt    <= '0;
      stall_count <= '0;
      hazard_err  <= 1'b0;
    end else begin
      if (PC_En)
        PC <= pc_next;

      if (flush) begin
        IF_ID_instr <= '0;
        IF_ID_pc4   <= '0;
      end else if (IFID_ctrl) begin
        IF_ID_instr <= instr_in;
        IF_ID_pc4   <= pc4_in;
      end

      if (bubble) begin
        ID_EX_ctrl <= '0;
        ID_EX_rt   <= '0;
      end else begin
        ID_EX_ctrl <= ctrl_in;
        ID_EX_rt   <= IF_ID_instr[20:16];
      end

      // Only genuine load-use bubbles are counted; flushes are not stalls.
      if (!stall_ctrl && !flush && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);

      if (!legal)
        hazard_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_regs.sv
// Directed bench for pipe_stall_regs: expectations are queued as stimulus is
// driven and compared after each update; a 4-bit-counter instance covers saturation.
module tb_pipe_stall_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PC_En = 1'b0, IFID_ctrl = 1'b0, stall_ctrl = 1'b0, flush = 1'b0;
  logic [31:0] pc_next = '0, instr_in = '0, pc4_in = '0;
  logic [8:0]  ctrl_in = '0;

  logic [31:0] PC, IF_ID_instr, IF_ID_pc4;
  logic [4:0]  IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic [8:0]  ID_EX_ctrl;
  logic        lw_detected, hazard_err;
  logic [15:0] stall_count;

  logic [31:0] s_PC, s_instr, s_pc4;
  logic [4:0]  s_rs, s_rt, s_exrt;
  logic [8:0]  s_ctrl;
  logic        s_lw, s_err;
  logic [3:0]  s_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pipe_stall_regs #(.RESET_PC(32'h0040_0000), .CTRL_W(9), .MEMREAD_BIT(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .PC_En(PC_En), .IFID_ctrl(IFID_ctrl), .stall_ctrl(stall_ctrl),
    .flush(flush), .pc_next(pc_next), .instr_in(instr_in), .pc4_in(pc4_in), .ctrl_in(ctrl_in),
    .PC(PC), .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_rt(ID_EX_rt),
    .lw_detected(lw_detected), .stall_count(stall_count), .hazard_err(hazard_err)
  );

  pipe_stall_regs #(.RESET_PC(32'h0040_0000), .CTRL_W(9), .MEMREAD_BIT(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .PC_En(PC_En), .IFID_ctrl(IFID_ctrl), .stall_ctrl(stall_ctrl),
    .flush(flush), .pc_next(pc_next), .instr_in(instr_in), .pc4_in(pc4_in), .ctrl_in(ctrl_in),
    .PC(s_PC), .IF_ID_instr(s_instr), .IF_ID_pc4(s_pc4), .IF_ID_rs(s_rs),
    .IF_ID_rt(s_rt), .ID_EX_ctrl(s_ctrl), .ID_EX_rt(s_exrt),
    .lw_detected(s_lw), .stall_count(s_count), .hazard_err(s_err)
  );

  typedef enum int unsigned {
    S_PC, S_INSTR, S_PC4, S_RS, S_RT, S_EXCTRL, S_EXRT, S_LW, S_CNT, S_ERR, S_SATCNT
  } sel_t;

  typedef struct {
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] obs(sel_t sel);
    case (sel)
      S_PC:     return PC;
      S_INSTR:  return IF_ID_instr;
      S_PC4:    return IF_ID_pc4;
      S_RS:     return 32'(IF_ID_rs);
      S_RT:     return 32'(IF_ID_rt);
      S_EXCTRL: return 32'(ID_EX_ctrl);
      S_EXRT:   return 32'(ID_EX_rt);
      S_LW:     return 32'(lw_detected);
      S_CNT:    return 32'(stall_count);
      S_ERR:    return 32'(hazard_err);
      default:  return 32'(s_count);
    endcase
  endfunction

  task automatic expect_val(input sel_t sel, input logic [31:0] exp);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_q();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.sel.name(), o, e.exp);
      end
    end
  endtask

  task automatic drive(input logic pe, input logic ic, input logic sc, input logic fl);
    PC_En = pe;
    IFID_ctrl = ic;
    stall_ctrl = sc;
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_q();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset, checked without any clock edge.
    #1 reset = 1'b0;
    #1;
    expect_val(S_PC, 32'h0040_0000);
    expect_val(S_INSTR, 32'h0);
    expect_val(S_PC4, 32'h0);
    expect_val(S_RS, 32'h0);
    expect_val(S_RT, 32'h0);
    expect_val(S_EXCTRL, 32'h0);
    expect_val(S_EXRT, 32'h0);
    expect_val(S_LW, 32'h0);
    expect_val(S_CNT, 32'h0);
    expect_val(S_ERR, 32'h0);
    check_q();

    reset = 1'b1;
    drive(1, 1, 1, 0);
    pc_next = 32'h0040_0010;
    expect_val(S_PC, 32'h0040_0010);
    tick();

    // Mid-cycle asynchronous reset.
    #3 reset = 1'b0;
    #1;
    expect_val(S_PC, 32'h0040_0000);
    expect_val(S_EXCTRL, 32'h0);
    expect_val(S_CNT, 32'h0);
    check_q();
    reset = 1'b1;
    pc_next = 32'h0040_0004;
    expect_val(S_PC, 32'h0040_0004);
    expect_val(S_ERR, 32'h0);
    tick();

    // lw $8,0($0) fetched.
    instr_in = 32'h8C08_0000;
    pc4_in = 32'h0040_0008;
    pc_next = 32'h0040_0008;
    ctrl_in = 9'h000;
    expect_val(S_PC, 32'h0040_0008);
    expect_val(S_INSTR, 32'h8C08_0000);
    expect_val(S_PC4, 32'h0040_0008);
    expect_val(S_RT, 32'd8);
    expect_val(S_LW, 32'h0);
    tick();

    // lw decoded (MemRead set) moves to EX; dependent add $9,$8,$8 fetched.
    instr_in = 32'h0108_4820;
    pc4_in = 32'h0040_000C;
    pc_next = 32'h0040_000C;
    ctrl_in = 9'h01A;
    expect_val(S_PC, 32'h0040_000C);
    expect_val(S_INSTR, 32'h0108_4820);
    expect_val(S_RS, 32'd8);
    expect_val(S_EXCTRL, 32'h01A);
    expect_val(S_EXRT, 32'd8);
    expect_val(S_LW, 32'h1);
    tick();

    // Load-use stall: one bubble.
    drive(0, 0, 0, 0);
    instr_in = 32'h1234_5678;
    pc4_in = 32'h0040_0010;
    pc_next = 32'h0040_0010;
    ctrl_in = 9'h005;
    expect_val(S_PC, 32'h0040_000C);
    expect_val(S_INSTR, 32'h0108_4820);
    expect_val(S_PC4, 32'h0040_000C);
    expect_val(S_EXCTRL, 32'h0);
    expect_val(S_EXRT, 32'h0);
    expect_val(S_LW, 32'h0);
    expect_val(S_CNT, 32'd1);
    expect_val(S_ERR, 32'h0);
    tick();

    // Release: dependent instruction enters EX.
    drive(1, 1, 1, 0);
    instr_in = 32'h0000_0000;
    expect_val(S_PC, 32'h0040_0010);
    expect_val(S_INSTR, 32'h0);
    expect_val(S_EXCTRL, 32'h005);
    expect_val(S_EXRT, 32'd8);
    expect_val(S_CNT, 32'd1);
    tick();

    // Load a non-zero instruction so the flush has something to kill.
    instr_in = 32'h8C09_0004;
    pc4_in = 32'h0040_0014;
    pc_next = 32'h0040_0014;
    ctrl_in = 9'h000;
    expect_val(S_INSTR, 32'h8C09_0004);
    expect_val(S_PC, 32'h0040_0014);
    tick();

    // Flush together with a stall: flush wins over hold, PC held, no count.
    drive(0, 0, 0, 1);
    instr_in = 32'hAAAA_5555;
    pc_next = 32'h0040_0100;
    ctrl_in = 9'h1FF;
    expect_val(S_PC, 32'h0040_0014);
    expect_val(S_INSTR, 32'h0);
    expect_val(S_PC4, 32'h0);
    expect_val(S_EXCTRL, 32'h0);
    expect_val(S_CNT, 32'd1);
    expect_val(S_ERR, 32'h0);
    tick();

    // Flush with normal enables: PC still loads the target.
    drive(1, 1, 1, 1);
    instr_in = 32'h1111_1111;
    pc_next = 32'h0040_0200;
    expect_val(S_PC, 32'h0040_0200);
    expect_val(S_INSTR, 32'h0);
    expect_val(S_EXCTRL, 32'h0);
    expect_val(S_CNT, 32'd1);
    tick();

    // Inconsistent controls (1,0,1).
    drive(1, 0, 1, 0);
    instr_in = 32'h2222_0000;
    pc_next = 32'h0040_0204;
    ctrl_in = 9'h003;
    expect_val(S_ERR, 32'h1);
    expect_val(S_PC, 32'h0040_0204);
    expect_val(S_INSTR, 32'h0);
    expect_val(S_EXCTRL, 32'h003);
    expect_val(S_CNT, 32'd1);
    tick();

    drive(1, 1, 1, 0);
    expect_val(S_ERR, 32'h1);
    expect_val(S_INSTR, 32'h2222_0000);
    tick();

    // Reset clears the sticky flag and counter.
    #3 reset = 1'b0;
    #1;
    expect_val(S_ERR, 32'h0);
    expect_val(S_CNT, 32'h0);
    expect_val(S_SATCNT, 32'h0);
    expect_val(S_INSTR, 32'h0);
    expect_val(S_PC, 32'h0040_0000);
    check_q();
    reset = 1'b1;

    // Saturation of the 4-bit counter over 20 stall edges.
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      expect_val(S_SATCNT, (i > 15) ? 32'd15 : 32'(i));
      expect_val(S_CNT, 32'(i));
      tick();
    end
    expect_val(S_ERR, 32'h0);
    check_q();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
